// File: rtl/audio_pkg.sv
// Shared audio-path package: beep sequencer states, ms-to-cycle helper and the default sample width.
package audio_pkg;

    localparam int AUDIO_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } beep_state_t;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/audio_beep_sequencer_if.sv
// Request/status bundle of the beep sequencer. The abort wire exists only with AUDIO_SEQ_ABORT_EN.
interface audio_beep_sequencer_if
    import audio_pkg::*;
#(
    parameter int NUM_W   = 4,
    parameter int AUDIO_W = AUDIO_W_DEFAULT
);
    // start is a one-cycle request with no ready: it is sampled (with count and mode)
    // only while state is IDLE and dropped otherwise; done pulses for one cycle on return
    // to IDLE, and busy is high exactly while state is ON or GAP.
    logic               start;
    logic [NUM_W-1:0]   count;
    logic               mode;
`ifdef AUDIO_SEQ_ABORT_EN
    logic               abort;
`endif
    logic               busy;
    logic               done;
    logic [AUDIO_W-1:0] audio_out;
    beep_state_t        state;

`ifdef AUDIO_SEQ_ABORT_EN
    modport master (output start, count, mode, abort, input busy, done, audio_out, state);
    modport slave  (input start, count, mode, abort, output busy, done, audio_out, state);
`else
    modport master (output start, count, mode, input busy, done, audio_out, state);
    modport slave  (input start, count, mode, output busy, done, audio_out, state);
`endif

endinterface

// File: rtl/tone_square_gen.sv
// Square-wave phase generator; level is the value the tone takes after the coming edge,
// so the sequencer can register its sample in the same process as its state.
module tone_square_gen #(
    parameter int HALF = 10
) (
    input  logic clk100M,
    input  logic reset,
    input  logic restart,
    input  logic en,
    output logic level
);
    localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] LAST = PW'(HALF - 1);

    logic [PW-1:0] phase_q;
    logic          level_q;
    logic          wrap;

    assign wrap = en && (phase_q == LAST);

    always_comb begin
        level = level_q;
        if (restart)
            level = 1'b1;
        else if (wrap)
            level = ~level_q;
    end

    always_ff @(posedge clk100M or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            level_q <= 1'b0;
        end else begin
            level_q <= level;
            if (restart || wrap)
                phase_q <= '0;
            else if (en)
                phase_q <= phase_q + PW'(1);
        end
    end

endmodule

// File: rtl/audio_beep_sequencer.sv
// Beep sequencer: pulse train (mode 0) or one scaled continuous beep (mode 1) of a square tone.
// Optional feature macro: AUDIO_SEQ_ABORT_EN adds the abort input.
module audio_beep_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TONE_HZ   = 200,
    parameter int AUDIO_W   = AUDIO_W_DEFAULT,
    parameter int AMPLITUDE = 12'hFFF,
    parameter int NUM_W     = 4,
    parameter int ON_MS     = 100,
    parameter int OFF_MS    = 100
) (
    input  logic clk100M,
    input  logic reset,
    audio_beep_sequencer_if.slave bus
);
    localparam int NUM_MAX   = 2**NUM_W - 1;
    localparam int ON_CYC    = ms_to_cycles(CLK_HZ, ON_MS);
    localparam int OFF_CYC   = ms_to_cycles(CLK_HZ, OFF_MS);
    localparam int HALF      = CLK_HZ / (2 * TONE_HZ);
    localparam int DUR_ON_W  = $clog2(NUM_MAX * ON_CYC + 1);
    localparam int DUR_OFF_W = $clog2(OFF_CYC + 1);
    localparam int DUR_W     = (DUR_ON_W > DUR_OFF_W) ? DUR_ON_W : DUR_OFF_W;

    localparam logic [DUR_W-1:0]   ON_V  = DUR_W'(ON_CYC);
    localparam logic [DUR_W-1:0]   OFF_V = DUR_W'(OFF_CYC);
    localparam logic [AUDIO_W-1:0] AMP_V = AUDIO_W'(AMPLITUDE);

    if (ON_CYC < 1 || OFF_CYC < 1 || HALF < 1) begin : g_bad_timing
        $error("audio_beep_sequencer: ON_CYC, OFF_CYC and HALF must all be at least 1");
    end
    if (AMPLITUDE < 0 || AMPLITUDE > 2**AUDIO_W - 1) begin : g_bad_amp
        $error("audio_beep_sequencer: AMPLITUDE does not fit AUDIO_W");
    end

    beep_state_t        state_q;
    logic [NUM_W-1:0]   rem_q;
    logic               mode_q;
    logic [DUR_W-1:0]   dur_q;
    logic               abort_req;
    logic               start_ok;
    logic               enter_on;
    logic               tone_level;
    logic [AUDIO_W-1:0] tone_amp;

`ifdef AUDIO_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign start_ok  = bus.start && (bus.count != '0);
    // Every entry to ON restarts the tone phase, high first.
    assign enter_on  = ((state_q == IDLE) && start_ok) ||
                       ((state_q == GAP) && (dur_q == '0) && !abort_req);
    assign tone_amp  = tone_level ? AMP_V : '0;
    assign bus.state = state_q;

    tone_square_gen #(.HALF(HALF)) u_tone (
        .clk100M (clk100M),
        .reset   (reset),
        .restart (enter_on),
        .en      (state_q == ON),
        .level   (tone_level)
    );

    always_ff @(posedge clk100M or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            mode_q        <= 1'b0;
            dur_q         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.audio_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q       <= ON;
                        rem_q         <= bus.count;
                        mode_q        <= bus.mode;
                        dur_q         <= bus.mode ? (DUR_W'(bus.count) * ON_V - DUR_W'(1))
                                                  : (ON_V - DUR_W'(1));
                        bus.busy      <= 1'b1;
                        bus.audio_out <= tone_amp;
                    end
                end
                ON: begin
                    if (abort_req || (dur_q == '0 && (mode_q || rem_q == NUM_W'(1)))) begin
                        state_q       <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.audio_out <= '0;
                    end else if (dur_q == '0) begin
                        state_q       <= GAP;
                        rem_q         <= rem_q - NUM_W'(1);
                        dur_q         <= OFF_V - DUR_W'(1);
                        bus.audio_out <= '0;
                    end else begin
                        dur_q         <= dur_q - DUR_W'(1);
                        bus.audio_out <= tone_amp;
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        state_q       <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.audio_out <= '0;
                    end else if (dur_q == '0) begin
                        state_q       <= ON;
                        dur_q         <= ON_V - DUR_W'(1);
                        bus.audio_out <= tone_amp;
                    end else begin
                        dur_q <= dur_q - DUR_W'(1);
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.audio_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_beep_sequencer.md
# audio_beep_sequencer

Parametrised beep sequencer for the audio path. A one-cycle `start` with a count either plays that many discrete beeps separated by silent gaps, or one continuous beep whose length scales with the count. The tone is an internally generated square wave of configurable pitch and amplitude. The 12-bit default sample output feeds the audio DAC output stage in place of the single fixed-tone duration beeper.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency
- `TONE_HZ`, 200, square-wave tone frequency
- `AUDIO_W`, 12, sample width
- `AMPLITUDE`, 12'hFFF, sample value during tone-high half-period (must fit `AUDIO_W`)
- `NUM_W`, 4, count width; max count `NUM_MAX = 2**NUM_W-1`
- `ON_MS`, 100, beep length (mode 0) / per-count length (mode 1)
- `OFF_MS`, 100, gap between beeps (mode 0 only)

Ports (one clock; reset is asynchronous and active-high):
- `clk100M`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `count`  in  `NUM_W`  number of beeps / length multiplier, captured with `start`
- `mode`  in  1  0 = pulse train, 1 = continuous beep, captured with `start`
- `abort`  in  1  present only with `AUDIO_SEQ_ABORT_EN`
- `busy`  out  1  high in ON or GAP
- `done`  out  1  one-cycle pulse on return to IDLE
- `audio_out`  out  `AUDIO_W`  sample; 0 when silent

## Operation
Derived constants:
- `ON_CYC = CLK_HZ/1000*ON_MS`, `OFF_CYC = CLK_HZ/1000*OFF_MS`, `HALF = CLK_HZ/(2*TONE_HZ)`
- All are integer divisions, and each must be ≥1. Elaborate with an error otherwise.

States are IDLE, ON, GAP. On reset, state is IDLE and all outputs are 0.

- **IDLE:** if `start` is high and `count` ≠ 0, latch `count` and `mode` and go to ON. If `start` is high and `count` = 0, stay in IDLE and pulse nothing.
- **ON:** the duration counter runs for `ON_CYC` cycles in mode 0, or `count*ON_CYC` cycles in mode 1 (full-width product, no truncation). When it expires:
  - mode 1: go to IDLE.
  - mode 0 with remaining beeps > 1: decrement and go to GAP.
  - mode 0 with remaining beeps = 1: go to IDLE.
- **GAP:** lasts `OFF_CYC` cycles, then go to ON. There is no gap after the last beep.
- **Tone:** the phase counter restarts at every entry to ON, and the tone starts high. It toggles every `HALF` cycles. `audio_out` is `AMPLITUDE` while ON and the tone is high, and 0 otherwise.
- **`start` while busy:** ignored. The latched count and mode are unchanged.
- **Duration counter width:** `$clog2(NUM_MAX*ON_CYC+1)`, or the `OFF_CYC` width if that is larger.

## Timing
- `start` is sampled at edge k. `busy` is high and the first `audio_out = AMPLITUDE` appear after edge k. State and `audio_out` are updated in the same registered process.
- An ON phase lasts exactly its cycle count; a GAP lasts exactly `OFF_CYC`.
- `done` is high for the single cycle following the edge that enters IDLE. `busy` falls at that same edge.
- A `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE.
- Reset asserted mid-operation forces IDLE, `audio_out` = 0 and `busy` = 0 immediately (asynchronous). No `done` is emitted.

## Configuration
`AUDIO_SEQ_ABORT_EN`:
- **Defined:** the `abort` port exists. `abort` high in ON or GAP enters IDLE at the next edge, sets `audio_out` to 0 and pulses `done`. `abort` has priority over phase expiry. In IDLE, `abort` is ignored and `start` proceeds normally.
- **Undefined:** no `abort` port, and a sequence always runs to completion.

## Structure
- The shared package `audio_pkg` holds:
  - the state enum `beep_state_t` (IDLE/ON/GAP)
  - a function `ms_to_cycles(clk_hz, ms)`
  - the default `AUDIO_W` constant, shared with other audio blocks
- Sub-module `tone_square_gen` contains the phase counter. Its inputs are `clk100M`, `reset`, `restart` and `en`, with parameter `HALF`. Its output is the 1-bit level. The sequencer applies `AMPLITUDE`.

## Test plan
All tests use `CLK_HZ`=20_000, `TONE_HZ`=1000 (`HALF`=10), `ON_MS`=2 (40 cycles) and `OFF_MS`=1 (20 cycles).
- **Mode 0, count 3:** three 40-cycle bursts separated by two 20-cycle zeros. Each burst reads 10×FFF, 10×0, 10×FFF, 10×0. `busy` is high for 160 cycles, then `done` pulses once.
- **Mode 1, count 3:** a single 120-cycle tone with no gap. `done` comes 120 cycles after `busy` rises.
- **Count 0 with `start`:** `busy`, `done` and `audio_out` stay 0.
- **`start` (count 5) during beep 2 of a count-2 sequence:** ignored. Total busy time is 100 cycles. A `start` coincident with `done` launches a new sequence.
- **Reset at cycle 50 of a mode 0, count 3 sequence:** `audio_out`, `busy` and `done` are 0 immediately. The next `start` behaves exactly as from power-up.
- **With `AUDIO_SEQ_ABORT_EN`:** `abort` in GAP of a count-3 sequence gives IDLE and a `done` pulse on the next cycle, with no further tone. `abort` in IDLE has no effect.
